// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types, defaults and round-robin pick for cmp_share_arb
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int K_DEF = 8;
  localparam int N_DEF = 4;

  // Upper bound on requester count supported by rr_pick.
  localparam int MAX_N = 32;
  localparam int MAX_W = $clog2(MAX_N);

  // First set bit of req scanning ptr, ptr+1, ... wrapping at n.
  // Scans the farthest distance first so the nearest hit wins.
  function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
    int idx;
    rr_pick = ptr;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[MAX_W-1:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/cmp_core.sv
// rtl/cmp_core.sv - combinational K-bit magnitude comparator, ripple LSB to MSB
module cmp_core #(
  parameter int K = 8
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic         gt,
  output logic         eq
);

  // Each slice overrides the lower-bit verdict when its bits differ.
  always_comb begin
    gt = 1'b0;
    eq = 1'b1;
    for (int i = 0; i < K; i++) begin
      gt = (a[i] & ~b[i]) | (~(a[i] ^ b[i]) & gt);
      eq = eq & ~(a[i] ^ b[i]);
    end
  end

endmodule

// File: rtl/cmp_share_arb.sv
// rtl/cmp_share_arb.sv - round-robin sharing of one comparator among N requesters (CMP_SIGNED_EN selects signed compare)
module cmp_share_arb
  import cmp_pkg::*;
#(
  parameter int K   = K_DEF,
  parameter int N   = N_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*K-1:0] a_flat,
  input  logic [N*K-1:0] b_flat,
  output logic [N-1:0]   ack,
  output logic           gt,
  output logic           eq,
  output logic [IDW-1:0] id,
  output logic           busy
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [K-1:0]   a_q, a_d;
  logic [K-1:0]   b_q, b_d;
  logic           gt_q, gt_d;
  logic           eq_q, eq_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           busy_q, busy_d;

  logic [MAX_N-1:0] req_ext;
  logic [IDW-1:0]   grant_idx;
  logic [K-1:0]     cmp_a, cmp_b;
  logic             cmp_gt, cmp_eq;

  // Widen req to the scan function's fixed width and pick the next winner.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    grant_idx      = IDW'(rr_pick(req_ext, int'(ptr_q), N));
  end

`ifdef CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign cmp_a = {~a_q[K-1], a_q[K-2:0]};
  assign cmp_b = {~b_q[K-1], b_q[K-2:0]};
`else
  assign cmp_a = a_q;
  assign cmp_b = b_q;
`endif

  cmp_core #(.K(K)) u_cmp_core (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (cmp_gt),
    .eq (cmp_eq)
  );

  // Sequencer: grant and latch in IDLE, capture result in LOAD, release in DONE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    gt_d    = 1'b0;
    eq_d    = 1'b0;
    ack_d   = '0;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          id_d    = grant_idx;
          a_d     = a_flat[grant_idx*K +: K];
          b_d     = b_flat[grant_idx*K +: K];
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        gt_d        = cmp_gt;
        eq_d        = cmp_eq;
        ack_d[id_q] = 1'b1;
        busy_d      = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        ptr_d   = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and outputs are registered; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ack  = ack_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign id   = id_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_cmp_share_arb.sv
// tb/tb_cmp_share_arb.sv - directed self-checking bench for cmp_share_arb
module tb_cmp_share_arb;

`ifdef CMP_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_flat;
  logic [31:0] b_flat;
  logic [3:0]  ack;
  logic        gt;
  logic        eq;
  logic [1:0]  id;
  logic        busy;

  int n_checks;
  int n_errors;

  cmp_share_arb #(.K(8), .N(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .ack    (ack),
    .gt     (gt),
    .eq     (eq),
    .id     (id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    a_flat[i*8 +: 8] = a;
    b_flat[i*8 +: 8] = b;
  endtask

  // Waits (bounded) for an ack; e_wait counts negedges from the call.
  task automatic expect_ack(input string tag, input logic [3:0] e_ack, input logic e_gt,
                            input logic e_eq, input logic [1:0] e_id, input int e_wait);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0000 && n < 20);
    check({tag, "_lat"}, n, e_wait);
    check({tag, "_ack"}, ack, e_ack);
    check({tag, "_gt"}, gt, e_gt);
    check({tag, "_eq"}, eq, e_eq);
    check({tag, "_id"}, id, e_id);
    check({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [7:0] CA [4] = '{8'h10, 8'h30, 8'hF0, 8'h01};
  localparam logic [7:0] CB [4] = '{8'h20, 8'h30, 8'h0F, 8'hFF};

  initial begin
    logic [3:0] c_gt;
    logic [3:0] c_eq;
    int         cid;
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    a_flat = '0;
    b_flat = '0;
    c_gt   = {SGN, ~SGN, 1'b0, 1'b0};
    c_eq   = 4'b0010;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack, 4'b0000);
    check("rst_gt", gt, 1'b0);
    check("rst_eq", eq, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_id", id, 2'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_ack", ack, 4'b0000);

    // Full contention from ptr=0: order 0,1,2,3,0, one ack every 3 cycles
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) set_ops(i, CA[i], CB[i]);
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      cid = s % 4;
      expect_ack($sformatf("cont%0d", s), 4'(1 << cid), c_gt[cid], c_eq[cid], 2'(cid),
                 (s == 0) ? 3 : 2);
      @(posedge clk);
      #1 req[cid] = 1'b0;
      if (s == 4) req = 4'b0000;
      @(negedge clk);
      check($sformatf("cont%0d_pulse", s), ack, 4'b0000);
      if (s != 4) begin
        @(posedge clk);
        #1 req[cid] = 1'b1;
      end
    end

    // Single request, 80 vs 7F
    @(posedge clk);
    #1;
    set_ops(0, 8'h80, 8'h7F);
    req = 4'b0001;
    expect_ack("single", 4'b0001, ~SGN, 1'b0, 2'd0, 3);
    @(posedge clk);
    #1 req = 4'b0000;

    // Equal operands on requester 2
    @(posedge clk);
    #1;
    set_ops(2, 8'h55, 8'h55);
    req = 4'b0100;
    expect_ack("equal", 4'b0100, 1'b0, 1'b1, 2'd2, 3);
    @(posedge clk);
    #1 req = 4'b0000;

    // Wrap: requester 3 from ptr=0, then ptr must wrap to 0
    do_reset();
    set_ops(3, 8'hFF, 8'h00);
    req = 4'b1000;
    expect_ack("wrap3", 4'b1000, ~SGN, 1'b0, 2'd3, 3);
    @(posedge clk);
    #1;
    set_ops(0, 8'h00, 8'h01);
    set_ops(3, 8'h02, 8'h02);
    req = 4'b1001;
    expect_ack("wrap0", 4'b0001, 1'b0, 1'b0, 2'd0, 3);
    @(posedge clk);
    #1 req[0] = 1'b0;
    expect_ack("wrap3b", 4'b1000, 1'b0, 1'b1, 2'd3, 3);
    @(posedge clk);
    #1 req = 4'b0000;

    // Reset pulse during LOAD discards the result; held req is served afterwards
    do_reset();
    set_ops(1, 8'h42, 8'h41);
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("midop_busy", busy, 1'b1);
    check("midop_id", id, 2'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midop_clr_busy", busy, 1'b0);
    check("midop_clr_id", id, 2'd0);
    @(negedge clk);
    check("midop_noack", ack, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_ack("midop", 4'b0010, 1'b1, 1'b0, 2'd1, 3);
    @(posedge clk);
    #1 req = 4'b0000;
    @(negedge clk);
    check("midop_end", ack, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cmp_share_arb.md
# cmp_share_arb

Round-robin arbiter and sequencer that shares one K-bit magnitude comparator among N requesters. Each requester presents an operand pair and holds a request. The block grants one requester at a time, registers its operands, runs the shared comparator and returns a one-cycle acknowledge with the gt/eq result. It sits between the client blocks and the single comparator instance, so that only one comparator datapath exists in the design.

## Interface
- K, 8: operand width in bits (K ≥ 2)
- N, 4: number of requesters (N ≥ 2)
- IDW, $clog2(N): width of the served-requester index

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req  in  N  per-requester request, level
- a_flat  in  N*K  operand a; requester i uses bits [i*K +: K]
- b_flat  in  N*K  operand b; same slicing as a_flat
- ack  out  N  one-hot, one-cycle pulse marking result valid for requester i
- gt  out  1  a > b for the acknowledged request; valid only while ack ≠ 0
- eq  out  1  a == b for the acknowledged request; valid only while ack ≠ 0
- id  out  IDW  index of the requester being served; valid while busy
- busy  out  1  high in LOAD and DONE

## Operation
- FSM states: IDLE, LOAD, DONE.
- **IDLE**
  - If req == 0, stay in IDLE.
  - Otherwise grant the first set req bit scanning ptr, ptr+1, … mod N.
  - Latch the granted a/b slices into a_r/b_r, latch the index into id, then go to LOAD.
- **LOAD**
  - The comparator evaluates a_r/b_r.
  - Register its gt/eq outputs into gt_r/eq_r, then go to DONE.
- **DONE**
  - Drive ack[id]=1, gt=gt_r, eq=eq_r.
  - Update ptr = (id+1) mod N, then go to IDLE.
- **Requester rule**
  - Hold req and operands stable from assertion until ack is sampled high.
  - Deassert req at the edge on which ack is seen.
  - Changing operands after the IDLE grant edge has no effect, because operands are already latched.
- **Grant is never revoked.** If req drops after the grant, the result is still delivered and ack still pulses.
- **Unsigned compare:** gt = (a_r > b_r), eq = (a_r == b_r), full K-bit width, no carry-out.
- **Outside DONE:** ack = 0, gt = 0, eq = 0.
- **Fairness:** with all N requests held, the service order is ptr, ptr+1, …, wrapping. No requester waits longer than N services.

## Timing
- **Reset values:** state = IDLE, ptr = 0, a_r = b_r = 0, gt_r = eq_r = 0, ack = 0, gt = 0, eq = 0, id = 0, busy = 0.
- **Reset mid-operation** (LOAD or DONE): everything clears immediately and any in-flight result is discarded with no ack. A requester still holding req is re-arbitrated from ptr = 0 after reset is released.
- **Latency:** req sampled high at IDLE edge T → ack high during cycle T+2, i.e. registered at edges T+1 and T+2.
- **Throughput:** one service per 3 cycles; back-to-back grants occur with no idle gap.
- **Simultaneous events:**
  - A new req arriving during LOAD or DONE waits for IDLE.
  - When the served requester still has req high in IDLE after DONE (protocol violation), ptr has already advanced past it, so other requesters win; if it is the only one, it is served again.
- **Outputs:** ack, gt, eq, id and busy are register outputs with no combinational path from inputs.

## Configuration
- **CMP_SIGNED_EN defined:** operands are two's complement. The MSB of both a_r and b_r is inverted before the comparator, so gt means signed a > b. eq is unaffected.
- **CMP_SIGNED_EN undefined:** unsigned comparison as above.

## Structure
- **Package cmp_pkg:**
  - state enum (IDLE, LOAD, DONE)
  - default K = 8 and N = 4 constants
  - a function for round-robin next-index from (req, ptr)
- **Sub-module cmp_core:**
  - parameter K, combinational, inputs a and b, outputs gt and eq
  - ripple bit-slice, LSB to MSB
  - instantiated exactly once

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles → ack=0, gt=0, eq=0, busy=0, id=0; release with req=0 → stays IDLE.
- **Single request:** req=4'b0001, a0=8'h80, b0=8'h7F at edge T → ack=4'b0001 in cycle T+2, gt=1, eq=0. With CMP_SIGNED_EN → gt=0.
- **Equal operands:** req[2] with a2=b2=8'h55 → ack=4'b0100, gt=0, eq=1, id=2.
- **Full contention:** req=4'b1111 held, with each requester dropping its req on its ack and reasserting it 1 cycle later → ack order 0,1,2,3,0, one ack every 3 cycles.
- **Wrap:** only req[3] (a=8'hFF, b=8'h00) from ptr=0 → served with gt=1; next single req[0] is served in 3 cycles; ptr=0 after the first service.
- **Reset mid-op:** req[1] granted, rst_n pulsed low during LOAD → no ack; req[1] held → ack[1] 3 cycles after rst_n rises, correct result.
